multi_tap_rate_tracking: RTL and testbench
==========================================

Name: multi_tap_rate_tracking

Overview:
- Parametrised successor to the generation path's half-rate target tracker.
- Computes the next edge target of the generated clock plus TAP_COUNT-1 equally spaced intra-half-period phase targets, and strobes each tap as the shared free-running rate counter reaches it.
- Runs a tracking FSM and, optionally, a bounded phase-resync correction driven by recovered-clock edges.
- Sits between the rate/delta measurement logic and the clock generator's edge/strobe outputs.

Parameters:
- RATE_COUNTER_WIDTH, 16: width of rates, counter and all targets.
- TAP_COUNT, 4: taps per half period; power of two, at least 2. Taps sit at k/TAP_COUNT for k = 1..TAP_COUNT-1.
- RESYNC_SHIFT, 2: right-shift applied to the measured phase error (loop gain).
- MAX_CORRECTION, 8: magnitude clamp on any single correction, in counter ticks.

Ports:
- clk  in  1  system clock
- async_rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  clock enable; no state changes when low, except reset
- generation_en_i  in  1  enables tracking
- clear_state_i  in  1  synchronous clear to IDLE
- high_rate_i  in  RATE_COUNTER_WIDTH  high half-period length
- low_rate_i  in  RATE_COUNTER_WIDTH  low half-period length
- counter_current_i  in  RATE_COUNTER_WIDTH  free-running counter, wraps modulo 2^W
- gen_clk_level_i  in  1  current generated clock level
- gen_edge_i  in  1  generated clock valid edge, either polarity
- recovered_edge_i  in  1  recovered clock valid edge
- deltas_locked_in_i  in  1  recovered deltas stable
- half_rate_target_o  out  RATE_COUNTER_WIDTH  counter value of the next generated edge
- tap_targets_o  out  (TAP_COUNT-1)*RATE_COUNTER_WIDTH  packed tap targets; tap 1 in the LSBs
- tap_strobe_o  out  TAP_COUNT-1  one-cycle pulse per tap reached
- active_half_rate_o  out  RATE_COUNTER_WIDTH  rate of the half period in progress
- inactive_half_rate_o  out  RATE_COUNTER_WIDTH  rate of the opposite half period
- tracking_o  out  1  FSM is in TRACKING
- overrun_o  out  1  one-cycle pulse: edge arrived before all taps fired

Behaviour:
- Reset (async_rst_n low): all outputs and registers are 0, FSM is IDLE. Release is synchronous to clk.
- FSM:
  - IDLE -> ARMED when generation_en_i=1.
  - ARMED -> TRACKING on the first gen_edge_i.
  - ARMED or TRACKING -> IDLE when generation_en_i=0.
  - Any state -> IDLE when clear_state_i=1, which wins over every other event. In that cycle all targets, rates, tap index and pending correction are zeroed.
- Edge load, on gen_edge_i in ARMED or TRACKING:
  - Let C = counter_current_i.
  - Let R = high_rate_i if gen_clk_level_i=0, else low_rate_i.
  - Let R' = the other rate.
  - half_rate_target = C + R + corr. corr is the pending signed correction; it is consumed and cleared on this load.
  - tap k target = C + ((R*k) >> log2(TAP_COUNT)). The product is computed at 2W width, then truncated.
  - active_half_rate = R; inactive_half_rate = R'.
  - Tap index is reset to 0.
  - Registered outputs are visible the next cycle.
- All additions are modulo 2^W; wrap-around is legal. Comparisons are equality only.
- Tap strobe:
  - In TRACKING with clk_en=1, tap_strobe_o[idx] pulses for one cycle when counter_current_i == tap target idx+1 and idx < TAP_COUNT-1; idx then increments.
  - Taps fire strictly in order. At most one tap strobes per cycle.
- Suppression: if R < TAP_COUNT, taps are suppressed for that half period (no strobes, no overrun).
- Overrun: gen_edge_i with idx < TAP_COUNT-1 and taps not suppressed -> overrun_o pulses one cycle. The edge load still proceeds.
- Same-cycle collision: a tap match and gen_edge_i in the same cycle -> the edge wins; no strobe, overrun flagged.
- tracking_o is asserted exactly when the FSM is in TRACKING.

Optional Feature:
- Macro: MULTI_TAP_RATE_TRACKING_RESYNC_EN.
- Defined:
  - The counter value at each gen_edge_i is stored as S.
  - On recovered_edge_i in TRACKING with deltas_locked_in_i=1: e = signed(counter_current_i - S).
  - If |e| < active_half_rate/2: corr = clamp(e >>> RESYNC_SHIFT, -MAX_CORRECTION, +MAX_CORRECTION). A newer measurement overwrites an unconsumed one.
  - recovered_edge_i in the same cycle as gen_edge_i gives e=0.
- Undefined: corr is constantly 0, recovered_edge_i and deltas_locked_in_i are ignored, and the resync registers are absent.

Test Plan:
- Reset/arm: reset, generation_en_i=1, gen_edge_i with level 0, C=100, high_rate_i=40 -> next cycle half_rate_target_o=140, tap targets 110/120/130, active=40, inactive=low_rate_i, tracking_o=1.
- Tap sequence: sweep counter 100..140 -> tap_strobe_o bits 0, 1, 2 pulse at 110, 120, 130, one cycle each; no overrun.
- Wrap: W=16, C=65530, R=16 -> half_rate_target_o=10, taps at 65534, 2, 6, strobes fire in order across the wrap.
- Overrun/collision: gen_edge_i at counter 120 after only tap 1 fired -> overrun_o=1 for one cycle; new targets load from C=120.
- Clear: clear_state_i together with gen_edge_i in TRACKING -> FSM IDLE, all outputs 0, no load.
- Resync (macro defined): S=200, recovered_edge_i at 220 with locked, RESYNC_SHIFT=2 -> corr=+5, next edge target = C+R+5; with e=80 and R=100 -> ignored; with e=60 and R=200 -> corr clamped to +8.

Source files
------------

// File: rtl/multi_tap_rate_tracking.sv
// multi_tap_rate_tracking
// Tracks the next edge target of the generated clock, and TAP_COUNT-1 equally
// spaced phase targets inside the current half period. It strobes each tap as
// the shared free-running rate counter reaches it.
// Optional phase resync correction: define MULTI_TAP_RATE_TRACKING_RESYNC_EN.
// tap_strobe_o and overrun_o are registered, so each pulse appears on the cycle
// after the counter match or edge that caused it.
module multi_tap_rate_tracking #(
    parameter int RATE_COUNTER_WIDTH = 16,
    parameter int TAP_COUNT          = 4,
    parameter int RESYNC_SHIFT       = 2,
    parameter int MAX_CORRECTION     = 8
) (
    input  logic                                        clk,
    input  logic                                        async_rst_n,
    input  logic                                        clk_en,
    input  logic                                        generation_en_i,
    input  logic                                        clear_state_i,
    input  logic [RATE_COUNTER_WIDTH-1:0]               high_rate_i,
    input  logic [RATE_COUNTER_WIDTH-1:0]               low_rate_i,
    input  logic [RATE_COUNTER_WIDTH-1:0]               counter_current_i,
    input  logic                                        gen_clk_level_i,
    input  logic                                        gen_edge_i,
    input  logic                                        recovered_edge_i,
    input  logic                                        deltas_locked_in_i,
    output logic [RATE_COUNTER_WIDTH-1:0]               half_rate_target_o,
    output logic [(TAP_COUNT-1)*RATE_COUNTER_WIDTH-1:0] tap_targets_o,
    output logic [TAP_COUNT-2:0]                        tap_strobe_o,
    output logic [RATE_COUNTER_WIDTH-1:0]               active_half_rate_o,
    output logic [RATE_COUNTER_WIDTH-1:0]               inactive_half_rate_o,
    output logic                                        tracking_o,
    output logic                                        overrun_o
);

    localparam int W         = RATE_COUNTER_WIDTH;
    localparam int NTAPS     = TAP_COUNT - 1;
    localparam int TAP_SHIFT = $clog2(TAP_COUNT);
    localparam int IDX_W     = TAP_SHIFT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        TRACKING = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     tap_target [NTAPS];
    logic [IDX_W-1:0] tap_idx;
    logic             taps_suppressed;
    logic [W-1:0]     cur_tap;
    logic [NTAPS-1:0] strobe_onehot;
    logic [W-1:0]     rate_sel;
    logic [W-1:0]     rate_other;
    logic             running;
    logic             taps_pending;
    logic             edge_load;
    logic             tap_hit;
    logic             overrun_event;
    logic signed [W-1:0] corr;

    // Offset of tap k: (rate*k) >> log2(TAP_COUNT), taken from a double-width product
    function automatic logic [W-1:0] tap_offset(input logic [W-1:0] rate, input int k);
        tap_offset = W'(({{W{1'b0}}, rate} * (2*W)'(k)) >> TAP_SHIFT);
    endfunction

    // Rate of the half period that starts at this edge, chosen by the level being left
    assign rate_sel   = gen_clk_level_i ? low_rate_i  : high_rate_i;
    assign rate_other = gen_clk_level_i ? high_rate_i : low_rate_i;

    assign running       = (state == ARMED) || (state == TRACKING);
    assign taps_pending  = !taps_suppressed && (tap_idx < LAST_IDX);
    assign edge_load     = clk_en && !clear_state_i && generation_en_i && running && gen_edge_i;
    assign overrun_event = edge_load && (state == TRACKING) && taps_pending;
    assign tap_hit       = clk_en && !clear_state_i && generation_en_i && (state == TRACKING)
                           && !gen_edge_i && taps_pending && (counter_current_i == cur_tap);
    assign tracking_o    = (state == TRACKING);

    // Select the target of the next tap due and its one-hot strobe position
    always_comb begin
        cur_tap       = '0;
        strobe_onehot = '0;
        for (int k = 0; k < NTAPS; k++) begin
            if (tap_idx == IDX_W'(k)) begin
                cur_tap          = tap_target[k];
                strobe_onehot[k] = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; clear beats everything, disable beats an edge
    always_comb begin
        state_next = state;
        if (clk_en) begin
            if (clear_state_i) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE:     if (generation_en_i) state_next = ARMED;
                    ARMED:    if (!generation_en_i) state_next = IDLE;
                              else if (gen_edge_i) state_next = TRACKING;
                    TRACKING: if (!generation_en_i) state_next = IDLE;
                    default:  state_next = IDLE;
                endcase
            end
        end
    end

`ifdef MULTI_TAP_RATE_TRACKING_RESYNC_EN
    localparam logic signed [W-1:0] CORR_MAX = W'(MAX_CORRECTION);
    localparam logic signed [W-1:0] CORR_MIN = -CORR_MAX;

    logic [W-1:0]        edge_stamp;
    logic signed [W-1:0] phase_err;
    logic [W-1:0]        err_mag;
    logic                meas_ok;

    // Scale the phase error by the loop gain and bound a single step
    function automatic logic signed [W-1:0] clamp_corr(input logic signed [W-1:0] err);
        logic signed [W-1:0] scaled;
        scaled = err >>> RESYNC_SHIFT;
        if (scaled > CORR_MAX)      clamp_corr = CORR_MAX;
        else if (scaled < CORR_MIN) clamp_corr = CORR_MIN;
        else                        clamp_corr = scaled;
    endfunction

    // A recovered edge coinciding with a generated edge has zero phase error
    assign phase_err = gen_edge_i ? '0 : $signed(counter_current_i - edge_stamp);
    assign err_mag   = phase_err[W-1] ? $unsigned(-phase_err) : $unsigned(phase_err);
    assign meas_ok   = clk_en && !clear_state_i && generation_en_i && (state == TRACKING)
                       && recovered_edge_i && deltas_locked_in_i
                       && (err_mag < (active_half_rate_o >> 1));

    // Edge timestamp and pending correction; a newer measurement replaces an unconsumed one
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            edge_stamp <= '0;
            corr       <= '0;
        end else if (clk_en) begin
            if (clear_state_i) begin
                edge_stamp <= '0;
                corr       <= '0;
            end else begin
                if (edge_load) begin
                    edge_stamp <= counter_current_i;
                    corr       <= '0;
                end
                if (meas_ok) begin
                    corr <= clamp_corr(phase_err);
                end
            end
        end
    end
`else
    localparam int unused_resync_cfg = RESYNC_SHIFT + MAX_CORRECTION;
    logic unused_resync;
    assign unused_resync = recovered_edge_i ^ deltas_locked_in_i;
    assign corr          = '0;
`endif

    // Targets, rates, tap progress and the one-cycle strobe/overrun pulses
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            half_rate_target_o   <= '0;
            active_half_rate_o   <= '0;
            inactive_half_rate_o <= '0;
            tap_idx              <= '0;
            taps_suppressed      <= 1'b0;
            tap_strobe_o         <= '0;
            overrun_o            <= 1'b0;
            for (int k = 0; k < NTAPS; k++) tap_target[k] <= '0;
        end else if (clk_en) begin
            tap_strobe_o <= '0;
            overrun_o    <= 1'b0;
            if (clear_state_i) begin
                half_rate_target_o   <= '0;
                active_half_rate_o   <= '0;
                inactive_half_rate_o <= '0;
                tap_idx              <= '0;
                taps_suppressed      <= 1'b0;
                for (int k = 0; k < NTAPS; k++) tap_target[k] <= '0;
            end else if (edge_load) begin
                half_rate_target_o   <= counter_current_i + rate_sel + $unsigned(corr);
                active_half_rate_o   <= rate_sel;
                inactive_half_rate_o <= rate_other;
                tap_idx              <= '0;
                taps_suppressed      <= (rate_sel < W'(TAP_COUNT));
                overrun_o            <= overrun_event;
                for (int k = 0; k < NTAPS; k++) begin
                    tap_target[k] <= counter_current_i + tap_offset(rate_sel, k + 1);
                end
            end else if (tap_hit) begin
                tap_strobe_o <= strobe_onehot;
                tap_idx      <= tap_idx + IDX_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NTAPS; g++) begin : g_tap_pack
        assign tap_targets_o[g*W +: W] = tap_target[g];
    end

endmodule

// File: tb/tb_multi_tap_rate_tracking.sv
// Scoreboard bench for multi_tap_rate_tracking (W=16, TAP_COUNT=4).
// Stimulus pushes expected snapshots and pulses into queues; a negedge monitor
// pops and compares whenever the DUT shows a pulse or a snapshot is due.
module tb_multi_tap_rate_tracking;

    logic        clk = 1'b0;
    logic        async_rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        generation_en = 1'b0;
    logic        clear_state = 1'b0;
    logic [15:0] high_rate = '0;
    logic [15:0] low_rate = '0;
    logic [15:0] counter = '0;
    logic        gen_level = 1'b0;
    logic        gen_edge = 1'b0;
    logic        recovered_edge = 1'b0;
    logic        deltas_locked = 1'b0;
    logic [15:0] half_rate_target;
    logic [47:0] tap_targets;
    logic [2:0]  tap_strobe;
    logic [15:0] active_half_rate;
    logic [15:0] inactive_half_rate;
    logic        tracking;
    logic        overrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int          stamp;
        logic        full;
        logic [15:0] hrt, t1, t2, t3, act, inact;
        logic        trk;
    } snap_t;

    typedef struct {
        int         stamp;
        logic [2:0] strobe;
        logic       ovr;
    } ev_t;

    snap_t snap_q[$];
    ev_t   ev_q[$];

    multi_tap_rate_tracking #(
        .RATE_COUNTER_WIDTH(16),
        .TAP_COUNT(4),
        .RESYNC_SHIFT(2),
        .MAX_CORRECTION(8)
    ) dut (
        .clk                 (clk),
        .async_rst_n         (async_rst_n),
        .clk_en              (clk_en),
        .generation_en_i     (generation_en),
        .clear_state_i       (clear_state),
        .high_rate_i         (high_rate),
        .low_rate_i          (low_rate),
        .counter_current_i   (counter),
        .gen_clk_level_i     (gen_level),
        .gen_edge_i          (gen_edge),
        .recovered_edge_i    (recovered_edge),
        .deltas_locked_in_i  (deltas_locked),
        .half_rate_target_o  (half_rate_target),
        .tap_targets_o       (tap_targets),
        .tap_strobe_o        (tap_strobe),
        .active_half_rate_o  (active_half_rate),
        .inactive_half_rate_o(inactive_half_rate),
        .tracking_o          (tracking),
        .overrun_o           (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares due snapshots and every pulse the DUT presents
    always @(negedge clk) begin
        snap_t s;
        ev_t   e;
        if (async_rst_n) begin
            if (snap_q.size() > 0 && snap_q[0].stamp <= cyc) begin
                s = snap_q.pop_front();
                chk("tracking", 32'(tracking), 32'(s.trk));
                if (s.full) begin
                    chk("half_rate_target", 32'(half_rate_target), 32'(s.hrt));
                    chk("tap1_target", 32'(tap_targets[15:0]), 32'(s.t1));
                    chk("tap2_target", 32'(tap_targets[31:16]), 32'(s.t2));
                    chk("tap3_target", 32'(tap_targets[47:32]), 32'(s.t3));
                    chk("active_rate", 32'(active_half_rate), 32'(s.act));
                    chk("inactive_rate", 32'(inactive_half_rate), 32'(s.inact));
                end
            end
            if (tap_strobe != 3'b000 || overrun) begin
                if (ev_q.size() == 0 || ev_q[0].stamp > cyc) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: strobe=%b overrun=%b, expected none (cycle %0d)",
                             tap_strobe, overrun, cyc);
                end else begin
                    e = ev_q.pop_front();
                    chk("tap_strobe", 32'(tap_strobe), 32'(e.strobe));
                    chk("overrun", 32'(overrun), 32'(e.ovr));
                end
            end else if (ev_q.size() > 0 && ev_q[0].stamp <= cyc) begin
                e = ev_q.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL missing_pulse: strobe=000 overrun=0, expected strobe=%b overrun=%b (cycle %0d)",
                         e.strobe, e.ovr, cyc);
            end
        end
    end

    task automatic step(input logic [15:0] c, input logic ge, input logic lvl);
        counter   = c;
        gen_edge  = ge;
        gen_level = lvl;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_snap(input logic full, input logic [15:0] hrt, input logic [15:0] t1,
                            input logic [15:0] t2, input logic [15:0] t3, input logic [15:0] act,
                            input logic [15:0] inact, input logic trk);
        snap_t s;
        s.stamp = cyc; s.full = full; s.hrt = hrt; s.t1 = t1; s.t2 = t2; s.t3 = t3;
        s.act = act; s.inact = inact; s.trk = trk;
        snap_q.push_back(s);
    endtask

    task automatic exp_ev(input logic [2:0] strobe, input logic ovr);
        ev_t e;
        e.stamp = cyc; e.strobe = strobe; e.ovr = ovr;
        ev_q.push_back(e);
    endtask

    // Walk the counter without edges; s0..s2 are the counts where taps 1..3 are due
    task automatic sweep(input int a, input int b, input int s0, input int s1, input int s2);
        for (int v = a; v <= b; v++) begin
            step(16'(v), 1'b0, 1'b0);
            if (v == s0)      exp_ev(3'b001, 1'b0);
            else if (v == s1) exp_ev(3'b010, 1'b0);
            else if (v == s2) exp_ev(3'b100, 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 async_rst_n = 1'b1;

        // Reset state
        step(16'd0, 1'b0, 1'b0);
        exp_snap(1, 0, 0, 0, 0, 0, 0, 0);

        // Arm, then first edge at C=100, level 0 -> high rate 40
        generation_en = 1'b1;
        step(16'd0, 1'b0, 1'b0);
        exp_snap(0, 0, 0, 0, 0, 0, 0, 0);
        high_rate = 16'd40;
        low_rate  = 16'd60;
        step(16'd100, 1'b1, 1'b0);
        exp_snap(1, 140, 110, 120, 130, 40, 60, 1);

        // Taps fire at 110, 120, 130
        sweep(101, 139, 110, 120, 130);

        // Edge at 140, level 1 -> low rate 60; all taps done, no overrun
        step(16'd140, 1'b1, 1'b1);
        exp_snap(1, 200, 155, 170, 185, 60, 40, 1);

        // Only tap 1 fires before the next edge -> overrun
        sweep(141, 159, 155, -1, -1);
        step(16'd160, 1'b1, 1'b0);
        exp_ev(3'b000, 1'b1);
        exp_snap(1, 200, 170, 180, 190, 40, 60, 1);

        // Edge coincides with tap 1 match -> edge wins, overrun, no strobe
        sweep(161, 169, -1, -1, -1);
        step(16'd170, 1'b1, 1'b1);
        exp_ev(3'b000, 1'b1);
        exp_snap(1, 230, 185, 200, 215, 60, 40, 1);

        // Wrap: C=65530, R=16
        low_rate = 16'd16;
        step(16'd65530, 1'b1, 1'b1);
        exp_ev(3'b000, 1'b1);
        exp_snap(1, 10, 65534, 2, 6, 16, 40, 1);
        sweep(65531, 65545, 65534, 65538, 65542);
        step(16'd10, 1'b1, 1'b0);
        exp_snap(1, 50, 20, 30, 40, 40, 16, 1);

        // Rate below TAP_COUNT suppresses taps and the following overrun
        low_rate = 16'd3;
        step(16'd50, 1'b1, 1'b1);
        exp_ev(3'b000, 1'b1);
        exp_snap(1, 53, 50, 51, 52, 3, 40, 1);
        sweep(50, 52, -1, -1, -1);
        step(16'd53, 1'b1, 1'b0);
        exp_snap(1, 93, 63, 73, 83, 40, 3, 1);

        // Disable drops to IDLE; re-enable arms; clk_en low blocks the edge
        generation_en = 1'b0;
        step(16'd60, 1'b0, 1'b0);
        exp_snap(0, 0, 0, 0, 0, 0, 0, 0);
        generation_en = 1'b1;
        step(16'd61, 1'b0, 1'b0);
        exp_snap(0, 0, 0, 0, 0, 0, 0, 0);
        clk_en = 1'b0;
        step(16'd300, 1'b1, 1'b0);
        exp_snap(0, 0, 0, 0, 0, 0, 0, 0);
        clk_en = 1'b1;
        step(16'd300, 1'b1, 1'b0);
        exp_snap(1, 340, 310, 320, 330, 40, 3, 1);

        // Clear with a simultaneous edge and tap match: IDLE, all zero, no pulses
        clear_state = 1'b1;
        step(16'd310, 1'b1, 1'b0);
        exp_snap(1, 0, 0, 0, 0, 0, 0, 0);
        clear_state   = 1'b0;
        generation_en = 1'b0;
        step(16'd0, 1'b0, 1'b0);

`ifdef MULTI_TAP_RATE_TRACKING_RESYNC_EN
        generation_en = 1'b1;
        deltas_locked = 1'b1;
        step(16'd0, 1'b0, 1'b0);
        high_rate = 16'd100;
        low_rate  = 16'd100;
        step(16'd200, 1'b1, 1'b0);
        exp_snap(1, 300, 225, 250, 275, 100, 100, 1);
        // e=20 -> corr=+5
        recovered_edge = 1'b1;
        step(16'd220, 1'b0, 1'b0);
        recovered_edge = 1'b0;
        step(16'd230, 1'b1, 1'b1);
        exp_ev(3'b000, 1'b1);
        exp_snap(1, 335, 255, 280, 305, 100, 100, 1);
        // e=80 with R=100 -> ignored
        recovered_edge = 1'b1;
        step(16'd310, 1'b0, 1'b0);
        recovered_edge = 1'b0;
        high_rate = 16'd200;
        step(16'd320, 1'b1, 1'b0);
        exp_ev(3'b000, 1'b1);
        exp_snap(1, 520, 370, 420, 470, 200, 100, 1);
        // e=60 with R=200 -> 15 clamped to +8
        recovered_edge = 1'b1;
        step(16'd380, 1'b0, 1'b0);
        recovered_edge = 1'b0;
        step(16'd400, 1'b1, 1'b1);
        exp_ev(3'b000, 1'b1);
        exp_snap(1, 508, 425, 450, 475, 100, 200, 1);
        generation_en = 1'b0;
`endif

        repeat (3) step(16'd0, 1'b0, 1'b0);

        n_cmp++;
        if (ev_q.size() != 0 || snap_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expectations: got %0d pulses and %0d snapshots unchecked, expected 0",
                     ev_q.size(), snap_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
